// File: rtl/bcd_counter.sv
// -----------------------------------------------------------------------------
// bcd_counter
//   Synchronous 4-bit decade up-counter. It advances by one on every rising
//   edge of clk, counts 0..TERMINAL_COUNT and then wraps to 0. With the default
//   TERMINAL_COUNT of 9 it is a mod-10 (BCD) digit stage.
//
//   Any state above TERMINAL_COUNT, which is only reachable by power-up or an
//   upset, goes to 0 on the next non-reset edge. This means the counter can
//   never lock up.
//
// Parameters
//   TERMINAL_COUNT : last count before the wrap to 0. The legal range is 1..15.
//
// Ports
//   clk : system clock. All state changes on the rising edge.
//   rst : synchronous reset, active-high. It has priority over counting.
//   out : current count, binary-coded.
//   q0  : count bit 0 (LSB), identical to out[0].
//   q1  : count bit 1, identical to out[1].
//   q2  : count bit 2, identical to out[2].
//   q3  : count bit 3 (MSB), identical to out[3].
//
//   All outputs come straight from the four state flops. There is no
//   combinational path from the inputs to the outputs.
// -----------------------------------------------------------------------------
module bcd_counter #(
  parameter int TERMINAL_COUNT = 9
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] out,
  output logic       q0,
  output logic       q1,
  output logic       q2,
  output logic       q3
);

  localparam logic [3:0] TC = 4'(TERMINAL_COUNT);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       wrap;

  // Wrap both at the terminal count and from any illegal state above it.
  assign wrap = (state_q >= TC);

  // Per-bit next-state, written as T flip-flop equations:
  //   state_d[i] = state_q[i] ^ t[i]
  //   counting : t[i] = state_q[0] & ... & state_q[i-1]   (t[0] = 1)
  //   wrapping : t[i] = state_q[i]                         (clear every 1 bit)
  // Expanded for 4 bits while counting:
  //   t0 = 1, t1 = q0, t2 = q0&q1, t3 = q0&q1&q2
  always_comb begin
    logic carry;
    logic t;
    state_d = '0;
    carry   = 1'b1;
    t       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t          = wrap ? state_q[i] : carry;
      state_d[i] = state_q[i] ^ t;
      carry      = carry & state_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 4'b0000;
    end else begin
      state_q <= state_d;
    end
  end

  assign out = state_q;
  assign q0  = state_q[0];
  assign q1  = state_q[1];
  assign q2  = state_q[2];
  assign q3  = state_q[3];

endmodule

// File: tb/tb_bcd_counter.sv
// -----------------------------------------------------------------------------
// tb_bcd_counter
//   Self-checking bench for bcd_counter (TERMINAL_COUNT = 9).
//
//   The reference model is an integer that follows the counting rule in plain
//   arithmetic:
//     - reset        -> 0
//     - value > TC   -> 0
//     - otherwise    -> (value + 1) mod (TC + 1)
//
//   Inputs are driven on the falling edge. Outputs are sampled 1 ns after
//   the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bcd_counter;

  localparam int TC = 9;

  logic       clk;
  logic       rst;
  logic [3:0] out;
  logic       q0;
  logic       q1;
  logic       q2;
  logic       q3;

  int n_checks = 0;
  int n_fail   = 0;
  int model    = 0;

  bcd_counter #(.TERMINAL_COUNT(TC)) dut (
    .clk (clk),
    .rst (rst),
    .out (out),
    .q0  (q0),
    .q1  (q1),
    .q2  (q2),
    .q3  (q3)
  );

  // The first rising edge is at 5 ns. The period is 10 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive rst for one edge, advance the reference model, and return 1 ns
  // after the edge. This task only steps; it makes no comparisons.
  task automatic tick(input logic r);
    if (clk) @(negedge clk);
    rst = r;
    @(posedge clk);
    if (r || model > TC) model = 0;
    else                 model = (model + 1) % (TC + 1);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    model = 0;
    #1;
    n_checks++;
    if (out !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %0d, want 0", out);
    end
    n_checks++;
    if ({q3, q2, q1, q0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_bits: got %b, want 0000", {q3, q2, q1, q0});
    end
    $display("reset: out=%0d q=%b", out, {q3, q2, q1, q0});
  endtask

  // Run n non-reset edges and compare each one against the model.
  task automatic test_count(input string name, input int n);
    for (int k = 0; k < n; k++) begin
      tick(1'b0);
      n_checks++;
      if (out !== 4'(model)) begin
        n_fail++;
        $display("FAIL %s_out[%0d]: got %0d, want %0d", name, k, out, model);
      end
      n_checks++;
      if ({q3, q2, q1, q0} !== out) begin
        n_fail++;
        $display("FAIL %s_bits[%0d]: got %b, want %b", name, k, {q3, q2, q1, q0}, out);
      end
      n_checks++;
      if (out > 4'(TC)) begin
        n_fail++;
        $display("FAIL %s_range[%0d]: got %0d, want <= %0d", name, k, out, TC);
      end
      $display("%s: edge %0d out=%0d expected=%0d", name, k, out, model);
    end
  endtask

  // Bounded advance until the model holds the target value.
  task automatic advance_to(input int target);
    for (int k = 0; k < 2 * (TC + 1) && model != target; k++) tick(1'b0);
    n_checks++;
    if (out !== 4'(target)) begin
      n_fail++;
      $display("FAIL advance_to: got %0d, want %0d", out, target);
    end
  endtask

  task automatic test_mid_count_reset();
    advance_to(6);
    tick(1'b1);
    n_checks++;
    if (out !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset: got %0d, want 0", out);
    end
    $display("mid_reset: out=%0d expected=0", out);
    tick(1'b0);
    n_checks++;
    if (out !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_reset_resume: got %0d, want 1", out);
    end
    $display("mid_reset_resume: out=%0d expected=1", out);
  endtask

  task automatic test_sync_reset();
    advance_to(4);
    // Pulse rst entirely between two rising edges. The pulse is sampled by
    // no edge, so the count must be unaffected.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    n_checks++;
    if (out !== 4'd4) begin
      n_fail++;
      $display("FAIL sync_hold: got %0d, want 4", out);
    end
    tick(1'b0);
    n_checks++;
    if (out !== 4'd5) begin
      n_fail++;
      $display("FAIL sync_advance: got %0d, want 5", out);
    end
    $display("sync_reset: out=%0d expected=5", out);
  endtask

  task automatic test_illegal(input logic [3:0] bad);
    @(negedge clk);
    rst = 1'b0;
    force dut.state_q = bad;
    #1;
    release dut.state_q;
    model = int'(bad);
    n_checks++;
    if (out !== bad) begin
      n_fail++;
      $display("FAIL illegal_load: got %0d, want %0d", out, bad);
    end
    tick(1'b0);
    n_checks++;
    if (out !== 4'd0) begin
      n_fail++;
      $display("FAIL illegal_recover_%0d: got %0d, want 0", bad, out);
    end
    $display("illegal %0d: out=%0d expected=0", bad, out);
    test_count("after_illegal", TC);
  endtask

  task automatic test_random();
    logic r;
    for (int k = 0; k < 200; k++) begin
      r = ($urandom_range(0, 5) == 0);
      tick(r);
      n_checks++;
      if (out !== 4'(model) || {q3, q2, q1, q0} !== 4'(model)) begin
        n_fail++;
        $display("FAIL random[%0d]: got out=%0d q=%b, want %0d", k, out, {q3, q2, q1, q0}, model);
      end
      $display("random: edge %0d rst=%0b out=%0d expected=%0d", k, r, out, model);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_count("full_decade", TC + 1);
    test_count("second_wrap", TC + 1);
    test_mid_count_reset();
    test_sync_reset();
    test_illegal(4'd12);
    test_illegal(4'd15);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
